lsu_bus_bridge: RTL

Parametrised load/store bridge between the datapath MEM stage and the DRAM/peripheral port. Captures one memory request per handshake, drives the bus with stable byte-lane-aligned address, data and masks, waits a configurable number of read-latency cycles, and returns a lane-extracted, sign- or zero-extended load result. It generalises the former fixed zero- or one-cycle registered read path into a parametrised read-latency handshake with explicit valid/ready flow control.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 77 +++++++
 rtl/lsu_bus_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus bridge: size codes, FSM states
// and the byte-lane count helper.
package lsu_pkg;

    // Access size codes, identical to the bus size (mask) encoding.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Number of byte lanes on a bus of the given data width.
    function automatic int mask_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the bridge: store replication and byte-enable
// generation, and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic [OFF_W-1:0]         i_off,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [DATA_W-1:0]        i_rdata,
    output logic [DATA_W-1:0]        o_wdata,
    output logic [DATA_W/8-1:0]      o_wmask,
    output logic [DATA_W-1:0]        o_rdata
);

    localparam int MASK_W = mask_width(DATA_W);

    logic [15:0]       w_lanes;
    logic [15:0]       w_lanes_sh;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_keep;
    logic              w_sign;

    // Replicate the right-aligned store operand across every lane of its size.
    always_comb begin
        o_wdata = '0;
        case (i_size)
            SZ_B: for (int i = 0; i < MASK_W; i++)     o_wdata[8*i +: 8]   = i_wdata[7:0];
            SZ_H: for (int i = 0; i < MASK_W / 2; i++) o_wdata[16*i +: 16] = i_wdata[15:0];
            SZ_W: for (int i = 0; i < MASK_W / 4; i++) o_wdata[32*i +: 32] = i_wdata[31:0];
            default: o_wdata = i_wdata;
        endcase
    end

    // Byte enables: a run of 2^size ones placed at the lane offset.
    always_comb begin
        w_lanes = 16'h0000;
        case (i_size)
            SZ_B:    w_lanes = 16'h0001;
            SZ_H:    w_lanes = 16'h0003;
            SZ_W:    w_lanes = 16'h000F;
            default: w_lanes = 16'h00FF;
        endcase
        w_lanes_sh = w_lanes << i_off;
        o_wmask    = w_lanes_sh[MASK_W-1:0];
    end

    // Shift the addressed lane down, keep the access width, extend the rest.
    always_comb begin
        w_shifted = i_rdata >> {i_off, 3'b000};
        w_keep    = '1;
        w_sign    = w_shifted[DATA_W-1];
        case (i_size)
            SZ_B: begin
                w_keep = DATA_W'(8'hFF);
                w_sign = w_shifted[7];
            end
            SZ_H: begin
                w_keep = DATA_W'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            SZ_W: begin
                w_keep = DATA_W'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                w_keep = '1;
                w_sign = w_shifted[DATA_W-1];
            end
        endcase
        o_rdata = (w_shifted & w_keep) | ({DATA_W{w_sign & ~i_unsigned}} & ~w_keep);
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the MEM stage and the DRAM/peripheral port.
// One request is captured per handshake and the bus is driven purely from
// the captured registers until the response pulse. Loads wait RD_LATENCY
// cycles before bus_rdata is sampled.
// Optional build macro LSU_MISALIGN_EN: misaligned accesses fault (no bus
// strobe, rsp_err=1); without it the low address bits are forced to zero.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high when idle or in the response
// cycle, so a new request may be accepted in the same cycle rsp_valid pulses.
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_wen,
    output logic                bus_ren,
    output logic [1:0]          bus_mask,
    output logic [DATA_W/8-1:0] bus_wmask,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    output state_e              o_dbg_state
);

    localparam int         OFF_W = $clog2(DATA_W / 8);
    localparam logic [2:0] LAT   = 3'(RD_LATENCY);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [2:0]          r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_fault;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_busy;
    logic                w_rsp;
    logic                w_ready;
    logic                w_xfer;
    logic [2:0]          w_low_mask;
    logic                w_fault;
    logic [ADDR_W-1:0]   w_cap_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_wmask;
    logic [DATA_W-1:0]   w_rdata;

    assign w_busy  = (r_state == ST_BUSY);
    assign w_rsp   = w_busy && (r_cnt == 3'd0);
    assign w_ready = rst && (!w_busy || w_rsp);
    assign w_xfer  = req_valid && w_ready;

    // Address bits that must be zero for a naturally aligned access.
    always_comb begin
        w_low_mask = 3'b000;
        case (req_size)
            SZ_B:    w_low_mask = 3'b000;
            SZ_H:    w_low_mask = 3'b001;
            SZ_W:    w_low_mask = 3'b011;
            default: w_low_mask = 3'b111;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    assign w_fault    = |(req_addr[2:0] & w_low_mask);
    assign w_cap_addr = req_addr;
    assign rsp_err    = w_rsp & r_fault;
`else
    assign w_fault    = 1'b0;
    assign w_cap_addr = {req_addr[ADDR_W-1:3], req_addr[2:0] & ~w_low_mask};
    assign rsp_err    = 1'b0;
`endif

    // FSM state register; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state: enter BUSY on a transfer, leave only on a response with no recapture.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_rsp && !w_xfer) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latency counter: loaded on transfer, counts down to the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 3'd0;
        end else if (w_xfer) begin
            r_cnt <= (!req_we && !w_fault) ? LAT : 3'd0;
        end else if (w_busy && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Request capture registers; the bus is driven only from these.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_fault    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_xfer) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_fault    <= w_fault;
            r_addr     <= w_cap_addr;
            r_wdata    <= req_wdata;
        end
    end

    lsu_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_off      (r_addr[OFF_W-1:0]),
        .i_wdata    (r_wdata),
        .i_rdata    (bus_rdata),
        .o_wdata    (w_wdata),
        .o_wmask    (w_wmask),
        .o_rdata    (w_rdata)
    );

    assign req_ready   = w_ready;
    assign rsp_valid   = w_rsp;
    assign rsp_rdata   = (w_rsp && !r_we && !r_fault) ? w_rdata : '0;
    assign bus_addr    = w_busy ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus_wen     = w_busy && r_we && !r_fault;
    assign bus_ren     = w_busy && !r_we && !r_fault;
    assign bus_mask    = w_busy ? r_size : 2'b00;
    assign bus_wmask   = w_busy ? w_wmask : '0;
    assign bus_wdata   = w_busy ? w_wdata : '0;
    assign o_dbg_state = r_state;

endmodule
